// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: reset level, load/store aluop codes
// and a decoder that turns an aluop into access size, direction and signedness.
package dmem_ctrl_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      load;
        logic      store;
        logic      sign;
        mem_size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [7:0] op);
        mem_op_t d;
        d = '{load: 1'b0, store: 1'b0, sign: 1'b0, size: SZ_WORD};
        case (op)
            EXE_LB_OP:  d = '{load: 1'b1, store: 1'b0, sign: 1'b1, size: SZ_BYTE};
            EXE_LBU_OP: d = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: SZ_BYTE};
            EXE_LH_OP:  d = '{load: 1'b1, store: 1'b0, sign: 1'b1, size: SZ_HALF};
            EXE_LHU_OP: d = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: SZ_HALF};
            EXE_LW_OP:  d = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: SZ_WORD};
            EXE_SB_OP:  d = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: SZ_BYTE};
            EXE_SH_OP:  d = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: SZ_HALF};
            EXE_SW_OP:  d = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: SZ_WORD};
            default:    d = '{load: 1'b0, store: 1'b0, sign: 1'b0, size: SZ_WORD};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_fmt.sv
// Combinational big-endian byte-lane steering: store replication, byte enables,
// and load lane extraction with sign/zero extension.
module dmem_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    mem_op_t     w_dec;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_dec = decode_op(i_aluop);
        case (i_lane)
            2'b00:   w_byte = i_rdata[31:24];
            2'b01:   w_byte = i_rdata[23:16];
            2'b10:   w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = ZERO_WORD;
        o_load  = ZERO_WORD;
        case (w_dec.size)
            SZ_BYTE: begin
                o_be    = 4'b1000 >> i_lane;
                o_wdata = {4{i_reg2[7:0]}};
                o_load  = {{24{w_dec.sign & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_lane[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_reg2[15:0]}};
                o_load  = {{16{w_dec.sign & w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_reg2;
                o_load  = i_rdata;
            end
        endcase
        // Loads always fetch the whole word; the lane is picked on return.
        if (w_dec.load) begin
            o_be = 4'b1111;
        end
        if (!w_dec.load && !w_dec.store) begin
            o_be    = 4'b0000;
            o_wdata = ZERO_WORD;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller: one request/ack bus transaction per load/store
// instruction, stalling the pipeline until the slave acknowledges.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic        flush,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    output logic        stallreq,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        adel,
    output logic        ades
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_op;
    logic [1:0]  r_lane;
    logic        r_flush_seen;
    logic        r_d_req;
    logic        r_d_we;
    logic [31:0] r_d_addr;
    logic [3:0]  r_d_be;
    logic [31:0] r_d_wdata;
    logic [31:0] r_load_data;
    logic        r_load_valid;

    mem_op_t     w_dec;
    mem_op_t     w_held_dec;
    logic        w_active;
    logic        w_idle;
    logic        w_misalign;
    logic        w_start;
    logic        w_flushed;
    logic [7:0]  w_fmt_op;
    logic [1:0]  w_fmt_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    always_comb begin
        w_dec      = decode_op(mem_aluop);
        w_held_dec = decode_op(r_op);
        w_active   = (rst != RST_ENABLE);
        w_idle     = (r_state == S_IDLE);
        w_misalign = ((w_dec.size == SZ_HALF) && mem_mem_addr[0]) ||
                     ((w_dec.size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
        w_start    = w_active && w_idle && (w_dec.load || w_dec.store) &&
                     !w_misalign && !flush;
        w_flushed  = r_flush_seen || flush;
        // Formatter serves the incoming op in IDLE and the latched op afterwards.
        w_fmt_op   = w_idle ? mem_aluop : r_op;
        w_fmt_lane = w_idle ? mem_mem_addr[1:0] : r_lane;
    end

    dmem_fmt u_fmt (
        .i_aluop (w_fmt_op),
        .i_lane  (w_fmt_lane),
        .i_reg2  (mem_reg2),
        .i_rdata (d_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_load  (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state      <= S_IDLE;
            r_op         <= EXE_NOP_OP;
            r_lane       <= 2'b00;
            r_flush_seen <= 1'b0;
            r_d_req      <= 1'b0;
            r_d_we       <= 1'b0;
            r_d_addr     <= ZERO_WORD;
            r_d_be       <= 4'b0000;
            r_d_wdata    <= ZERO_WORD;
            r_load_data  <= ZERO_WORD;
            r_load_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_load_valid <= 1'b0;
                    if (w_start) begin
                        r_state      <= S_REQ;
                        r_op         <= mem_aluop;
                        r_lane       <= mem_mem_addr[1:0];
                        r_flush_seen <= 1'b0;
                        r_d_req      <= 1'b1;
                        r_d_we       <= w_dec.store;
                        r_d_addr     <= {mem_mem_addr[31:2], 2'b00};
                        r_d_be       <= w_be;
                        r_d_wdata    <= w_wdata;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_flush_seen <= 1'b1;
                    end
                    if (d_ack) begin
                        r_d_req <= 1'b0;
                        if (w_flushed) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DONE;
                            if (w_held_dec.load) begin
                                r_load_data  <= w_load;
                                r_load_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_load_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign d_req      = r_d_req;
    assign d_we       = r_d_we;
    assign d_addr     = r_d_addr;
    assign d_be       = r_d_be;
    assign d_wdata    = r_d_wdata;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign stallreq   = w_active && ((w_idle && w_start) || (r_state == S_REQ));
    assign adel       = w_active && w_idle && w_dec.load  && w_misalign;
    assign ades       = w_active && w_idle && w_dec.store && w_misalign;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl; load results are checked through a scoreboard queue.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        flush;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        stallreq;
    logic [31:0] load_data;
    logic        load_valid;
    logic        adel;
    logic        ades;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned lv_cnt = 0;
    int unsigned req_starts = 0;
    int unsigned stall_cnt = 0;
    int unsigned starts_before = 0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_q[$];

    logic [7:0]  t_op[4];
    logic [31:0] t_addr[4];
    logic [31:0] t_rdata[4];
    logic [31:0] t_exp[4];

    dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .flush        (flush),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_be         (d_be),
        .d_wdata      (d_wdata),
        .stallreq     (stallreq),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .adel         (adel),
        .ades         (ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %-24s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard side: every load_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (load_valid === 1'b1) begin
            lv_cnt++;
            chk("load_valid_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_load_data", load_data, e);
            end
        end
        if (d_req === 1'b1 && prev_req !== 1'b1) req_starts++;
        prev_req = d_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        t_op[0] = EXE_LH_OP;  t_addr[0] = 32'h7002; t_rdata[0] = 32'h1234_8001; t_exp[0] = 32'hFFFF_8001;
        t_op[1] = EXE_LHU_OP; t_addr[1] = 32'h7000; t_rdata[1] = 32'h8001_ABCD; t_exp[1] = 32'h0000_8001;
        t_op[2] = EXE_LB_OP;  t_addr[2] = 32'h7001; t_rdata[2] = 32'h127F_5566; t_exp[2] = 32'h0000_007F;
        t_op[3] = EXE_LW_OP;  t_addr[3] = 32'h7004; t_rdata[3] = 32'hDEAD_BEEF; t_exp[3] = 32'hDEAD_BEEF;

        rst = 1'b0; mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h3001; mem_reg2 = 32'h0;
        flush = 1'b0; d_ack = 1'b0; d_rdata = 32'h0;
        tick(); tick(); #1;
        chk("rst_d_req", d_req, 0);
        chk("rst_d_we", d_we, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_d_be", d_be, 0);
        chk("rst_d_wdata", d_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_adel", adel, 0);
        rst = 1'b1; mem_aluop = EXE_NOP_OP; mem_mem_addr = 32'h0;

        // LB 0x1003, ack in third REQ cycle
        tick(); mem_aluop = EXE_LB_OP; mem_mem_addr = 32'h1003; exp_q.push_back(32'hFFFF_FFF0);
        #1; stall_cnt = stallreq; chk("lb_idle_stall", stallreq, 1);
        tick(); #1; stall_cnt += stallreq;
        chk("lb_d_req", d_req, 1);
        chk("lb_d_addr", d_addr, 32'h1000);
        chk("lb_d_be", d_be, 4'b1111);
        chk("lb_d_we", d_we, 0);
        tick(); #1; stall_cnt += stallreq;
        tick(); d_ack = 1'b1; d_rdata = 32'h1122_33F0; #1; stall_cnt += stallreq;
        tick(); d_ack = 1'b0; #1; stall_cnt += stallreq;
        chk("lb_done_valid", load_valid, 1);
        chk("lb_done_d_req", d_req, 0);
        chk("lb_load_data", load_data, 32'hFFFF_FFF0);
        chk("lb_stall_cycles", stall_cnt, 4);
        mem_aluop = EXE_NOP_OP;
        tick(); #1; chk("lb_valid_pulse", load_valid, 0);

        // SH 0x2002, immediate ack
        tick(); mem_aluop = EXE_SH_OP; mem_mem_addr = 32'h2002; mem_reg2 = 32'h0000_BEEF;
        #1; chk("sh_idle_stall", stallreq, 1); chk("sh_ades", ades, 0);
        tick(); #1;
        chk("sh_d_req", d_req, 1);
        chk("sh_d_we", d_we, 1);
        chk("sh_d_be", d_be, 4'b0011);
        chk("sh_d_wdata", d_wdata, 32'hBEEF_BEEF);
        chk("sh_d_addr", d_addr, 32'h2000);
        d_ack = 1'b1;
        tick(); d_ack = 1'b0; #1;
        chk("sh_done_d_req", d_req, 0);
        chk("sh_done_stall", stallreq, 0);
        chk("sh_no_valid", load_valid, 0);
        mem_aluop = EXE_NOP_OP;

        // Misaligned accesses
        tick(); mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h3001; #1;
        chk("lw_mis_adel", adel, 1);
        chk("lw_mis_stall", stallreq, 0);
        tick(); #1; chk("lw_mis_no_req", d_req, 0);
        mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h3002; #1;
        chk("sw_mis_ades", ades, 1);
        chk("sw_mis_adel", adel, 0);
        tick(); #1; chk("sw_mis_no_req", d_req, 0);
        mem_aluop = EXE_NOP_OP;

        // LHU with flush during REQ: data discarded, DONE skipped
        tick(); mem_aluop = EXE_LHU_OP; mem_mem_addr = 32'h4000;
        tick(); flush = 1'b1; #1; chk("fl_req1", d_req, 1);
        tick(); flush = 1'b0; #1; chk("fl_req2_held", d_req, 1);
        tick(); #1; chk("fl_req3_held", d_req, 1);
        tick(); d_ack = 1'b1; d_rdata = 32'h8001_5A5A; mem_aluop = EXE_NOP_OP; #1;
        chk("fl_req4_held", d_req, 1);
        tick(); d_ack = 1'b0; #1;
        chk("fl_idle_d_req", d_req, 0);
        chk("fl_no_valid", load_valid, 0);
        chk("fl_stall", stallreq, 0);
        chk("fl_data_kept", load_data, 32'hFFFF_FFF0);
        tick(); #1; chk("fl_no_valid_late", load_valid, 0);

        // Reset mid-REQ, then a normal SW
        tick(); mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h6000; mem_reg2 = 32'h1111_2222;
        tick(); #1; chk("rr_req", d_req, 1);
        rst = 1'b0; #1; chk("rr_stall_in_rst", stallreq, 0);
        tick(); #1;
        chk("rr_req_dropped", d_req, 0);
        chk("rr_load_data_clr", load_data, 0);
        rst = 1'b1; mem_aluop = EXE_NOP_OP; d_ack = 1'b1;
        tick(); #1;
        chk("rr_ack_ignored", d_req, 0);
        chk("rr_ack_no_valid", load_valid, 0);
        chk("rr_ack_no_stall", stallreq, 0);
        d_ack = 1'b0;
        tick(); mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h6004; mem_reg2 = 32'hCAFE_F00D; #1;
        chk("sw_idle_stall", stallreq, 1);
        tick(); #1;
        chk("sw_d_req", d_req, 1);
        chk("sw_d_we", d_we, 1);
        chk("sw_d_be", d_be, 4'b1111);
        chk("sw_d_wdata", d_wdata, 32'hCAFE_F00D);
        chk("sw_d_addr", d_addr, 32'h6004);
        d_ack = 1'b1;
        tick(); d_ack = 1'b0; #1; chk("sw_done_stall", stallreq, 0);
        mem_aluop = EXE_NOP_OP;

        // Load lane / extension table
        for (int i = 0; i < 4; i++) begin
            tick(); mem_aluop = t_op[i]; mem_mem_addr = t_addr[i]; exp_q.push_back(t_exp[i]);
            tick(); d_ack = 1'b1; d_rdata = t_rdata[i];
            tick(); d_ack = 1'b0; mem_aluop = EXE_NOP_OP;
        end

        // Back-to-back LBU then SB; op held through DONE must not re-issue
        tick(); starts_before = req_starts;
        mem_aluop = EXE_LBU_OP; mem_mem_addr = 32'h5000; exp_q.push_back(32'h0000_00A5);
        tick(); d_ack = 1'b1; d_rdata = 32'hA511_2233;
        tick(); d_ack = 1'b0; #1;
        chk("b2b_done_d_req", d_req, 0);
        tick(); #1; chk("b2b_no_dup_req", d_req, 0);
        mem_aluop = EXE_SB_OP; mem_mem_addr = 32'h5001; mem_reg2 = 32'h0000_007E;
        tick(); #1;
        chk("sb_d_req", d_req, 1);
        chk("sb_d_be", d_be, 4'b0100);
        chk("sb_d_wdata", d_wdata, 32'h7E7E_7E7E);
        chk("sb_d_addr", d_addr, 32'h5000);
        d_ack = 1'b1;
        tick(); d_ack = 1'b0;
        tick(); mem_aluop = EXE_NOP_OP;
        tick(); tick();
        chk("b2b_bus_transactions", req_starts - starts_before, 2);
        chk("sb_queue_empty", exp_q.size(), 0);
        chk("load_valid_pulses", lv_cnt, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: rst is sampled only on the rising edge of clk, and rst==0 (`RstEnable) resets the block.
REQ-002 Port: clk  in  1  the block's only clock.
REQ-003 Port: rst  in  1  synchronous, active-low reset.
REQ-004 Port: mem_aluop  in  8  operation code from the EX/MEM latch.
REQ-005 Port: mem_mem_addr  in  32  byte address.
REQ-006 Port: mem_reg2  in  32  store source data.
REQ-007 Port: flush  in  1  pipeline flush.
REQ-008 Port: d_ack  in  1  bus slave completion, valid for one cycle.
REQ-009 Port: d_rdata  in  32  read data, valid with d_ack.
REQ-010 Port: d_req  out  1  bus request.
REQ-011 Port: d_we  out  1  bus write enable.
REQ-012 Port: d_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 Port: d_be  out  4  byte enables.
REQ-014 Port: d_wdata  out  32  write data.
REQ-015 Port: stallreq  out  1  stall request to the pipeline controller.
REQ-016 Port: load_data  out  32  formatted load result.
REQ-017 Port: load_valid  out  1  load_data is valid.
REQ-018 Port: adel  out  1  load address error.
REQ-019 Port: ades  out  1  store address error.

Function
REQ-020 Supported ops SHALL be LB, LBU, LH, LHU, LW, SB, SH and SW; every other aluop SHALL be treated as no memory access.
REQ-021 Byte order SHALL be big-endian: addr[1:0]=00 selects [31:24]; 01 selects [23:16]; 10 selects [15:8]; 11 selects [7:0].
REQ-022 Misalignment SHALL be defined as halfword access with addr[0]=1, or word access with addr[1:0]!=00.
REQ-023 On misalignment, adel (load) or ades (store) SHALL assert combinationally in IDLE, with no bus request and no stallreq.
REQ-024 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-025 IDLE -> REQ SHALL occur when the op is a valid, aligned memory op and flush=0; bus outputs are registered on that edge.
REQ-026 In IDLE, stallreq SHALL be 1 combinationally whenever the IDLE -> REQ condition holds.
REQ-027 In REQ, d_req SHALL be 1 and bus outputs SHALL be held stable; stallreq SHALL be 1.
REQ-028 In REQ, when d_ack=1: for a load, load_data SHALL capture the formatted d_rdata; then go to DONE, or to IDLE if flush was seen during this transaction.
REQ-029 In DONE, d_req=0, stallreq=0 and, for a load, load_valid=1; next state SHALL be IDLE unconditionally.
REQ-030 DONE SHALL ignore the still-present mem_aluop (one access per instruction); latency SHALL be 2 cycles plus the ack wait.
REQ-031 Store data SHALL be replicated: SB -> {4{reg2[7:0]}}, SH -> {2{reg2[15:0]}}, SW -> reg2.
REQ-032 Byte enables SHALL be: SB one-hot per REQ-021 (00 -> 1000); SH 1100/0011; SW 1111; loads 1111.
REQ-033 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-034 Flush in IDLE SHALL suppress the request.
REQ-035 Flush in REQ SHALL NOT drop d_req: the FSM waits for ack, discards the data, and DONE is skipped (load_valid stays 0).
REQ-036 d_ack outside REQ SHALL be ignored.
REQ-037 d_ack in the first REQ cycle SHALL be accepted.

Reset
REQ-038 On rst==0 at a clock edge: state=IDLE; d_req=0, d_we=0, d_addr=0, d_be=0, d_wdata=0, load_data=0, load_valid=0, and the flush-seen flag SHALL clear.
REQ-039 Reset mid-REQ SHALL deassert d_req on the next edge; the bus slave tolerates an abandoned request.
REQ-040 adel/ades/stallreq SHALL be 0 while rst==0.

Structure
REQ-041 Load/store aluop codes (EXE_*_OP), `ZeroWord and `RstEnable SHALL come from the shared defines header; FSM state encodings SHALL be local.
REQ-042 One sub-module, dmem_fmt (combinational byte-lane steering and extension), SHALL hold REQ-031..033.

Verification
REQ-043 LB addr 0x1003, d_rdata 0x112233F0, ack after 2 cycles -> load_data 0xFFFFFFF0, load_valid 1 cycle, stallreq high 4 cycles.
REQ-044 SH addr 0x2002, reg2 0x0000BEEF, immediate ack -> d_we=1, d_be=0011, d_wdata 0xBEEFBEEF, d_addr 0x2000.
REQ-045 LW addr 0x3001 -> adel=1, d_req stays 0, stallreq=0.
REQ-046 LHU addr 0x4000, flush during REQ, ack 3 cycles later with 0x8001xxxx -> d_req held until ack, load_valid never 1, returns to IDLE.
REQ-047 Reset asserted mid-REQ -> d_req=0 next edge; later ack ignored; a following SW completes normally.
REQ-048 Back-to-back LBU 0x5000 then SB 0x5001 -> two distinct bus transactions, no duplicate access in DONE.
